// File: rtl/rd_512b_from_bram_pkg.sv
// Shared constants and state encoding for the 512-bit row BRAM access blocks.
// The row/word address map is common with wr_512b_to_bram.
package rd_512b_from_bram_pkg;

    localparam int WORD_W        = 32;
    localparam int WORDS_PER_ROW = 16;
    localparam int ROW_W         = 9;
    localparam int WIDX_W        = $clog2(WORDS_PER_ROW);
    localparam int ADDR_W        = ROW_W + WIDX_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } rd_state_e;

endpackage

// File: rtl/rd_512b_from_bram_if.sv
// Word-level read bus between a row reader (master) and the BRAM controller (slave).
interface rd_512b_from_bram_if #(
    parameter int ADDR_W = rd_512b_from_bram_pkg::ADDR_W,
    parameter int WORD_W = rd_512b_from_bram_pkg::WORD_W
);
    logic [ADDR_W-1:0] addr;
    logic              trig;
    logic [WORD_W-1:0] data;
    logic              done;

    modport master (output addr, output trig, input data, input done);
    modport slave  (input addr, input trig, output data, output done);
endinterface

// File: rtl/rd_512b_from_bram.sv
// Fetches one 512-bit row as sequential word reads over the trig/done handshake
// and presents the assembled row with a level done until the requester lets go.
module rd_512b_from_bram #(
    parameter int WORD_W        = rd_512b_from_bram_pkg::WORD_W,
    parameter int WORDS_PER_ROW = rd_512b_from_bram_pkg::WORDS_PER_ROW,
    parameter int ROW_W         = rd_512b_from_bram_pkg::ROW_W
) (
    input  logic                            i_clk,
    input  logic                            i_rstn,
    input  logic                            i_trig,
    output logic                            o_done,
    input  logic [ROW_W-1:0]                i_rd_row_num,
    output logic [WORD_W*WORDS_PER_ROW-1:0] o_rd_data_512b,
    rd_512b_from_bram_if.master             bram
);
    import rd_512b_from_bram_pkg::*;

    localparam int K_W   = $clog2(WORDS_PER_ROW);
    localparam int ROWDW = WORD_W * WORDS_PER_ROW;

    rd_state_e         state_q, state_n;
    logic [ROW_W-1:0]  row_q, row_n;
    logic [K_W-1:0]    k_q, k_n;
    logic [ROWDW-1:0]  buf_q, buf_n;
    logic [ROWDW-1:0]  data_q, data_n;
    logic              trig_q, done_q;

    always_comb begin
        state_n = state_q;
        row_n   = row_q;
        k_n     = k_q;
        buf_n   = buf_q;
        data_n  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (i_trig) begin
                    row_n   = i_rd_row_num;
                    k_n     = '0;
                    state_n = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bram.done) begin
                    buf_n[int'(k_q)*WORD_W +: WORD_W] = bram.data;
                    // Publish the row only once the last word is merged in.
                    if (k_q == K_W'(WORDS_PER_ROW - 1)) begin
                        data_n  = buf_n;
                        state_n = ST_DONE;
                    end else begin
                        k_n     = k_q + K_W'(1);
                        state_n = ST_GAP;
                    end
                end
            end
            // One idle cycle forces a trig falling edge between words.
            ST_GAP:  state_n = ST_REQ;
            ST_DONE: begin
                if (!i_trig) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            k_q     <= '0;
            buf_q   <= '0;
            data_q  <= '0;
            trig_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            row_q   <= row_n;
            k_q     <= k_n;
            buf_q   <= buf_n;
            data_q  <= data_n;
            trig_q  <= (state_n == ST_REQ);
            done_q  <= (state_n == ST_DONE);
        end
    end

    assign bram.addr      = {row_q, k_q};
    assign bram.trig      = trig_q;
    assign o_done         = done_q;
    assign o_rd_data_512b = data_q;

endmodule

// File: tb/tb_rd_512b_from_bram.sv
// Directed bench for rd_512b_from_bram with a latency-programmable BRAM responder.
module bram_model_rd (
    input  logic        clk,
    input  logic        rst_n,
    input  int          n_lat,
    input  logic        trig,
    input  logic [12:0] addr,
    output logic        done,
    output logic [31:0] data
);
    logic [31:0] mem [0:8191];
    logic        trig_d;
    int          cnt;

    // Preload: word k of row r holds {r, k}, which equals its own address.
    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 32'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_d <= 1'b0;
            cnt    <= 0;
            done   <= 1'b0;
            data   <= '0;
        end else begin
            trig_d <= trig;
            done   <= 1'b0;
            if (trig && !trig_d) begin
                if (n_lat <= 1) begin
                    done <= 1'b1;
                    data <= mem[addr];
                end else begin
                    cnt <= n_lat - 1;
                end
            end else if (cnt > 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    done <= 1'b1;
                    data <= mem[addr];
                end
            end
        end
    end
endmodule

module tb_rd_512b_from_bram;
    logic         clk = 1'b0;
    logic         i_rstn;
    logic         i_trig;
    logic         o_done;
    logic [8:0]   i_rd_row_num;
    logic [511:0] o_rd_data_512b;
    logic         mdl_done;
    logic [31:0]  mdl_data;
    logic         inj_done;
    int           n_lat;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    rd_512b_from_bram_if bram ();
    assign bram.done = mdl_done | inj_done;
    assign bram.data = mdl_data;

    rd_512b_from_bram dut (
        .i_clk          (clk),
        .i_rstn         (i_rstn),
        .i_trig         (i_trig),
        .o_done         (o_done),
        .i_rd_row_num   (i_rd_row_num),
        .o_rd_data_512b (o_rd_data_512b),
        .bram           (bram)
    );

    bram_model_rd u_mdl (
        .clk   (clk),
        .rst_n (i_rstn),
        .n_lat (n_lat),
        .trig  (bram.trig),
        .addr  (bram.addr),
        .done  (mdl_done),
        .data  (mdl_data)
    );

    // Record the address of every word request and how long trig was low before it.
    logic [12:0] addr_q [$];
    int          gap_q  [$];
    logic        trig_prev = 1'b0;
    int          low_cnt   = 0;

    always @(negedge clk) begin
        if (bram.trig) begin
            if (!trig_prev) begin
                addr_q.push_back(bram.addr);
                gap_q.push_back(low_cnt);
            end
            low_cnt = 0;
        end else begin
            low_cnt++;
        end
        trig_prev = bram.trig;
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] row_data(input logic [8:0] r);
        logic [511:0] d;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = 32'({r, 4'(k)});
        return d;
    endfunction

    task automatic do_read(input logic [8:0] row, input int nlat, input int drop_at,
                           input int chg_at, input bit inj_gap, input string tag);
        logic [511:0] prev;
        int  cyc;
        int  early;
        bit  got;
        bit  injected;
        int  n;
        @(negedge clk);
        n_lat = nlat;
        addr_q.delete();
        gap_q.delete();
        prev         = o_rd_data_512b;
        i_rd_row_num = row;
        i_trig       = 1'b1;
        @(posedge clk);
        cyc = 0; got = 0; early = 0; injected = 0;
        while (!got && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            inj_done = 1'b0;
            if (o_done) begin
                got = 1;
            end else begin
                if (o_rd_data_512b !== prev) early++;
                if (cyc == drop_at) i_trig = 1'b0;
                if (cyc == chg_at) i_rd_row_num = ~row;
                if (inj_gap && !injected && cyc > 3 && !bram.trig) begin
                    inj_done = 1'b1;
                    injected = 1;
                end
            end
        end
        i_trig = 1'b0;
        check({tag, " latency"}, 512'(cyc), 512'(16 * (nlat + 1) + 15));
        check({tag, " data held until done"}, 512'(early), 512'(0));
        check({tag, " row data"}, o_rd_data_512b, row_data(row));
        check({tag, " word requests"}, 512'(addr_q.size()), 512'(16));
        n = (addr_q.size() < 16) ? addr_q.size() : 16;
        for (int k = 0; k < n; k++)
            check($sformatf("%s addr[%0d]", tag, k), 512'(addr_q[k]), 512'({row, 4'(k)}));
        for (int k = 1; k < n; k++)
            check($sformatf("%s trig gap[%0d]", tag, k), 512'(gap_q[k]), 512'(1));
        if (inj_gap) check({tag, " gap pulse injected"}, 512'(injected), 512'(1));
        @(posedge clk);
        #1;
        check({tag, " done one cycle"}, 512'(o_done), 512'(0));
    endtask

    initial begin
        int cyc;
        i_rstn       = 1'b0;
        i_trig       = 1'b0;
        i_rd_row_num = '0;
        inj_done     = 1'b0;
        n_lat        = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        i_rstn = 1'b1;
        @(negedge clk);
        check("reset o_done", 512'(o_done), 512'(0));
        check("reset bram trig", 512'(bram.trig), 512'(0));
        check("reset bram addr", 512'(bram.addr), 512'(0));
        check("reset row data", o_rd_data_512b, 512'(0));

        do_read(9'h123, 1, -1, -1, 1'b0, "basic");
        do_read(9'h000, 1, -1, -1, 1'b0, "row0");
        do_read(9'h1FF, 1, -1, -1, 1'b0, "row511");
        do_read(9'h0F0, 5, -1, -1, 1'b0, "slow");
        do_read(9'h07E, 1, 10, 12, 1'b1, "noise");

        // Reset in the middle of word 7 of a transfer.
        @(negedge clk);
        n_lat        = 1;
        i_rd_row_num = 9'h0AA;
        i_trig       = 1'b1;
        cyc          = 0;
        while (!(bram.trig && bram.addr[3:0] == 4'd7) && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("rst reached word 7", 512'(cyc < 400), 512'(1));
        #2;
        i_rstn = 1'b0;
        #1;
        check("midrst o_done", 512'(o_done), 512'(0));
        check("midrst bram trig", 512'(bram.trig), 512'(0));
        check("midrst bram addr", 512'(bram.addr), 512'(0));
        check("midrst row data", o_rd_data_512b, 512'(0));
        i_trig = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        i_rstn = 1'b1;
        do_read(9'h0AA, 1, -1, -1, 1'b0, "post-rst");

        do_read(9'h005, 1, -1, -1, 1'b0, "b2b row5");
        do_read(9'h006, 1, -1, -1, 1'b0, "b2b row6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
